// File: rtl/xnor_pop_seq_ctrl.sv
// xnor_pop_seq_ctrl
// Streams one binary dot-product job (NUM_CHUNKS chunks of CHUNK_W bits)
// through an external fixed-latency XNOR-popcount unit, then accumulates
// the per-chunk counts into a single result.
//
// Optional feature: define XNOR_POP_SEQ_THRESH_EN to add a threshold input
// (sampled at start) and a binarized output bit out_bit = (sum >= thresh).
//
// Handshake semantics (both the chunk input and the result output):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The producer keeps data stable while valid is high and ready is
//   low. The result side holds out_valid/out_sum until the transfer.
module xnor_pop_seq_ctrl #(
    parameter int CHUNK_W    = 128,
    parameter int NUM_CHUNKS = 8,
    parameter int PIPE_LAT   = 2,
    parameter int CNT_W      = $clog2(CHUNK_W) + 1,
    parameter int ACC_W      = $clog2(CHUNK_W * NUM_CHUNKS) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] in_x,
    input  logic [CHUNK_W-1:0] in_w,
    output logic [CHUNK_W-1:0] pc_xi,
    output logic [CHUNK_W-1:0] pc_wi,
    input  logic [CNT_W-1:0]   pc_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
`ifdef XNOR_POP_SEQ_THRESH_EN
    input  logic [ACC_W-1:0]   thresh,
    output logic               out_bit,
`endif
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A zero-latency unit still gets a 1-deep tag vector so the code stays
    // uniform; in that case the accept strobe itself is the retire strobe.
    localparam int TAG_D = (PIPE_LAT == 0) ? 1 : PIPE_LAT;
    localparam int IDX_W = $clog2(NUM_CHUNKS + 1);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t            state_q;
    logic              busy_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  out_sum_q;
    logic [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]  issued_q;
    logic [IDX_W-1:0]  retired_q;
    logic [TAG_D-1:0]  tag_q;
    logic [TAG_D-1:0]  tag_d;
`ifdef XNOR_POP_SEQ_THRESH_EN
    logic [ACC_W-1:0]  thresh_q;
    logic              out_bit_q;
`endif

    logic              accept;
    logic              retire;
    logic              last_accept;
    logic              last_retire;
    logic [ACC_W-1:0]  acc_sum;

    // The popcount unit registers internally, so operands pass straight through.
    assign pc_xi = in_x;
    assign pc_wi = in_w;

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign dbg_state = state_q;
`ifdef XNOR_POP_SEQ_THRESH_EN
    assign out_bit   = out_bit_q;
`endif

    // Accept/retire strobes, next tag vector and the accumulator adder.
    always_comb begin
        in_ready    = (state_q == S_FEED) && (issued_q < N_IDX) && !abort;
        accept      = in_valid && in_ready;
        retire      = (PIPE_LAT == 0) ? accept : tag_q[TAG_D-1];
        last_accept = accept && (issued_q == LAST_IDX);
        last_retire = retire && (retired_q == LAST_IDX);
        acc_sum     = acc_q + ACC_W'(pc_count);
        tag_d       = '0;
        tag_d[0]    = accept;
        for (int k = 1; k < TAG_D; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Controller FSM with registered outputs; abort overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            acc_q       <= '0;
            issued_q    <= '0;
            retired_q   <= '0;
            tag_q       <= '0;
`ifdef XNOR_POP_SEQ_THRESH_EN
            thresh_q    <= '0;
            out_bit_q   <= 1'b0;
`endif
        end else begin
            tag_q <= tag_d;
            if (abort && (state_q != S_IDLE)) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b0;
                acc_q       <= '0;
                issued_q    <= '0;
                retired_q   <= '0;
                tag_q       <= '0;
`ifdef XNOR_POP_SEQ_THRESH_EN
                out_bit_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q   <= S_FEED;
                            busy_q    <= 1'b1;
                            acc_q     <= '0;
                            issued_q  <= '0;
                            retired_q <= '0;
`ifdef XNOR_POP_SEQ_THRESH_EN
                            thresh_q  <= thresh;
`endif
                        end
                    end
                    S_FEED, S_DRAIN: begin
                        if (accept) begin
                            issued_q <= issued_q + 1'b1;
                        end
                        if (retire) begin
                            acc_q     <= acc_sum;
                            retired_q <= retired_q + 1'b1;
                        end
                        if (last_retire) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_sum_q   <= acc_sum;
`ifdef XNOR_POP_SEQ_THRESH_EN
                            out_bit_q   <= (acc_sum >= thresh_q);
`endif
                        end else if (last_accept) begin
                            state_q <= S_DRAIN;
                        end
                    end
                    S_DONE: begin
                        if (out_ready) begin
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xnor_pop_seq_ctrl.sv
// Bench for xnor_pop_seq_ctrl: directed scenarios plus randomized jobs,
// with expected sums pushed to a queue and checked by a monitor.
module tb_xnor_pop_seq_ctrl;

  localparam int CHUNK_W    = 128;
  localparam int NUM_CHUNKS = 8;
  localparam int PIPE_LAT   = 2;
  localparam int CNT_W      = $clog2(CHUNK_W) + 1;
  localparam int ACC_W      = $clog2(CHUNK_W * NUM_CHUNKS) + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [CHUNK_W-1:0] in_x;
  logic [CHUNK_W-1:0] in_w;
  logic [CHUNK_W-1:0] pc_xi;
  logic [CHUNK_W-1:0] pc_wi;
  logic [CNT_W-1:0]   pc_count;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [1:0]         dbg_state;
  logic [ACC_W-1:0]   thresh_v;
`ifdef XNOR_POP_SEQ_THRESH_EN
  logic               out_bit;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic             exp_bit_q[$];
  bit rdy_rand = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  xnor_pop_seq_ctrl #(
    .CHUNK_W(CHUNK_W), .NUM_CHUNKS(NUM_CHUNKS), .PIPE_LAT(PIPE_LAT),
    .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .pc_xi(pc_xi), .pc_wi(pc_wi), .pc_count(pc_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef XNOR_POP_SEQ_THRESH_EN
    .thresh(thresh_v), .out_bit(out_bit),
`endif
    .dbg_state(dbg_state)
  );

  // popcount unit model: count of equal bit positions, two register stages
  logic [CNT_W-1:0] pc_s1, pc_s2;
  always @(posedge clk) begin
    pc_s1 <= CNT_W'($countones(~(pc_xi ^ pc_wi)));
    pc_s2 <= pc_s1;
  end
  assign pc_count = pc_s2;

  // cycle bookkeeping for ready-count and latency observations
  int cyc = 0;
  int rdy_cnt = 0;
  int last_acc_cyc = 0;
  int rise_cyc = 0;
  bit ov_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (in_valid && in_ready) last_acc_cyc = cyc;
    if (in_ready) rdy_cnt = rdy_cnt + 1;
    if (out_valid && !ov_prev) rise_cyc = cyc;
    ov_prev = out_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: present one chunk and hold it until accepted (bounded)
  task automatic drive_chunk(input logic [CHUNK_W-1:0] x, input logic [CHUNK_W-1:0] w,
                             output bit ok);
    in_x = x;
    in_w = w;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input logic [ACC_W-1:0] thr);
    thresh_v = thr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // driver: one full job. mode 0 random, 1 x==w, 2 x==~w, 3 chunk i matches i+1 bits.
  // gap 0 back-to-back, 1 idle cycle between chunks, 2 random idles.
  // fixed_exp >= 0 overrides the model sum with a known constant.
  task automatic send_job(input int mode, input int gap, input int fixed_exp,
                          input logic [ACC_W-1:0] thr);
    logic [CHUNK_W-1:0] x, w, m;
    int sum, idle, e;
    bit ok;
    pulse_start(thr);
    sum = 0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      case (mode)
        1: w = x;
        2: w = ~x;
        3: begin m = '1; m = m << (i + 1); w = x ^ m; end
        default: w = {$urandom, $urandom, $urandom, $urandom};
      endcase
      idle = (gap == 1) ? ((i > 0) ? 1 : 0) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (idle) begin
        in_valid = 1'b0;
        in_x = {$urandom, $urandom, $urandom, $urandom};
        in_w = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
      end
      drive_chunk(x, w, ok);
      if (ok) sum += $countones(~(x ^ w));
    end
    e = (fixed_exp >= 0) ? fixed_exp : sum;
    exp_q.push_back(ACC_W'(e));
    exp_bit_q.push_back(ACC_W'(e) >= thr);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bit ok;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_x = '0; in_w = '0; out_ready = 1'b0; thresh_v = '0;

    fork
      // scoreboard monitor: compare every result handshake with the queue head
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(out_sum), 32'hFFFF_FFFF);
          end else begin
            logic [ACC_W-1:0] e;
            logic eb;
            e = exp_q.pop_front();
            eb = exp_bit_q.pop_front();
            chk("out_sum", 32'(out_sum), 32'(e));
`ifdef XNOR_POP_SEQ_THRESH_EN
            chk("out_bit", 32'(out_bit), 32'(eb));
`else
            if (eb === 1'bx) chk("exp_bit_x", 32'(eb), 32'd0);
`endif
          end
        end
      end
      // random backpressure on the result side
      forever begin
        @(posedge clk); #2;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_state", 32'(dbg_state), 0);
    @(posedge clk); #1;

    // all-matching chunks, back to back
    out_ready = 1'b1;
    begin
      int base;
      base = rdy_cnt;
      send_job(1, 0, 1024, 11'd1000);
      wait_idle();
      chk("ready_cycles", 32'(rdy_cnt - base), 32'd8);
      chk("latency", 32'(rise_cyc - last_acc_cyc), 32'(PIPE_LAT + 1));
    end

    // all-inverted chunks
    send_job(2, 0, 0, 11'd0);
    wait_idle();

    // i+1 matching bits per chunk, toggling valid, held result with start pulse
    out_ready = 1'b0;
    send_job(3, 1, 36, 11'd512);
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("stall_out_valid_rise", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = (k == 1);
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_sum", 32'(out_sum), 36);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_busy", 32'(busy), 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_hs_busy", 32'(busy), 0);
    chk("post_hs_out_valid", 32'(out_valid), 0);
    chk("post_hs_out_sum", 32'(out_sum), 36);
    @(posedge clk); #1;

    // abort after three accepts with tags in flight
    pulse_start(11'd0);
    for (int i = 0; i < 3; i++) drive_chunk({$urandom, $urandom, $urandom, $urandom},
                                            {$urandom, $urandom, $urandom, $urandom}, ok);
    abort = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_state", 32'(dbg_state), 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_out", 32'(seen), 0);
    @(posedge clk); #1;
    send_job(1, 0, 1024, 11'd0);
    wait_idle();

    // asynchronous reset in the middle of feeding
    pulse_start(11'd0);
    for (int i = 0; i < 4; i++) drive_chunk({$urandom, $urandom, $urandom, $urandom},
                                            {$urandom, $urandom, $urandom, $urandom}, ok);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_sum", 32'(out_sum), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized jobs with gaps and random backpressure
    rdy_rand = 1'b1;
    for (int j = 0; j < 10; j++) begin
      send_job(0, 2, -1, ACC_W'($urandom_range(400, 624)));
      wait_idle();
    end
    rdy_rand = 1'b0;
    out_ready = 1'b0;

    repeat (5) @(posedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
